// File: rtl/wb_queue_if.sv
// -----------------------------------------------------------------------------
// wb_queue_if
//   Bundles the producer handshakes, the register-file write port, the
//   forwarding lookup and the occupancy output of the write-back queue.
//
//   Signals
//     alu_valid/alu_ready/alu_dest/alu_data   ALU producer handshake
//     mem_valid/mem_ready/mem_dest/mem_data   load producer handshake
//     rf_port_busy                             register-file port borrowed
//     reg_write_en/_dest/_data                 register-file write port
//     fwd_addr_n / fwd_hit_n / fwd_data_n      forwarding lookups (n = 1, 2)
//     occupancy                                number of queued entries
//
//   Modports
//     master : environment side (producers, register file, readers)
//     slave  : the queue itself
// -----------------------------------------------------------------------------
interface wb_queue_if #(
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH) + 1
);
   logic          alu_valid;
   logic          alu_ready;
   logic [2:0]    alu_dest;
   logic [15:0]   alu_data;
   logic          mem_valid;
   logic          mem_ready;
   logic [2:0]    mem_dest;
   logic [15:0]   mem_data;
   logic          rf_port_busy;
   logic          reg_write_en;
   logic [2:0]    reg_write_dest;
   logic [15:0]   reg_write_data;
   logic [2:0]    fwd_addr_1;
   logic [2:0]    fwd_addr_2;
   logic          fwd_hit_1;
   logic          fwd_hit_2;
   logic [15:0]   fwd_data_1;
   logic [15:0]   fwd_data_2;
   logic [CW-1:0] occupancy;

   modport master (
      output alu_valid, alu_dest, alu_data,
      output mem_valid, mem_dest, mem_data,
      output rf_port_busy, fwd_addr_1, fwd_addr_2,
      input  alu_ready, mem_ready,
      input  reg_write_en, reg_write_dest, reg_write_data,
      input  fwd_hit_1, fwd_hit_2, fwd_data_1, fwd_data_2,
      input  occupancy
   );

   modport slave (
      input  alu_valid, alu_dest, alu_data,
      input  mem_valid, mem_dest, mem_data,
      input  rf_port_busy, fwd_addr_1, fwd_addr_2,
      output alu_ready, mem_ready,
      output reg_write_en, reg_write_dest, reg_write_data,
      output fwd_hit_1, fwd_hit_2, fwd_data_1, fwd_data_2,
      output occupancy
   );
endinterface

// File: rtl/wb_queue.sv
// -----------------------------------------------------------------------------
// wb_queue
//   Write-back queue in front of the 8x16-bit register file. Accepts results
//   from the load path (priority) and the ALU path, buffers them in order and
//   drains at most one entry per cycle into the single register-file write
//   port. Back-pressures producers when full and the port is borrowed.
//
//   Ports
//     clk    sole clock, rising edge
//     reset  asynchronous, active-high; clears all control state
//     bus    wb_queue_if.slave (handshakes, write port, forwarding, occupancy)
//
//   Optional feature macro: WB_FORWARD_EN
//     defined   : forwarding comparators drive fwd_hit_n / fwd_data_n
//     undefined : forwarding outputs tied to 0, fwd_addr_n ignored
// -----------------------------------------------------------------------------
module wb_queue #(
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input logic         clk,
   input logic         reset,
   wb_queue_if.slave   bus
);
   localparam int PW = $clog2(DEPTH);

   // Entry storage is not reset: occupancy gates every use of it.
   logic [2:0]    r_dest [DEPTH];
   logic [15:0]   r_data [DEPTH];
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [CW-1:0] r_occ;

   logic          w_empty;
   logic          w_pop;
   logic          w_push;
   logic          w_mem_ready;
   logic          w_alu_ready;
   logic [2:0]    w_in_dest;
   logic [15:0]   w_in_data;

   always_comb begin
      w_empty     = (r_occ == '0);
      w_pop       = !w_empty && !bus.rf_port_busy;
      // A pop frees a slot in the same cycle, so a full queue still accepts.
      w_mem_ready = (r_occ < CW'(DEPTH)) || w_pop;
      w_alu_ready = w_mem_ready && !bus.mem_valid;
      w_push      = (bus.mem_valid && w_mem_ready) || (bus.alu_valid && w_alu_ready);
      w_in_dest   = bus.mem_valid ? bus.mem_dest : bus.alu_dest;
      w_in_data   = bus.mem_valid ? bus.mem_data : bus.alu_data;
   end

   assign bus.mem_ready      = w_mem_ready;
   assign bus.alu_ready      = w_alu_ready;
   assign bus.reg_write_en   = w_pop;
   assign bus.reg_write_dest = w_empty ? 3'd0  : r_dest[r_rptr];
   assign bus.reg_write_data = w_empty ? 16'd0 : r_data[r_rptr];
   assign bus.occupancy      = r_occ;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_occ  <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_occ <= r_occ + 1'b1;
            2'b01:   r_occ <= r_occ - 1'b1;
            default: r_occ <= r_occ;
         endcase
      end
   end

   // At full with a pop, r_wptr equals r_rptr: the new entry overwrites the
   // head slot at the same edge the head is consumed.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_dest[r_wptr] <= w_in_dest;
         r_data[r_wptr] <= w_in_data;
      end
   end

`ifdef WB_FORWARD_EN
   // Scan oldest to youngest so the last match seen is the youngest one.
   // The entry being pushed is not yet in storage, so it is naturally excluded.
   function automatic logic [16:0] fwd_lookup(input logic [2:0] addr);
      logic [16:0]   res;
      logic [PW-1:0] idx;
      res = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = r_rptr + PW'(i);
         if ((CW'(i) < r_occ) && (r_dest[idx] == addr))
            res = {1'b1, r_data[idx]};
      end
      return res;
   endfunction

   logic [16:0] w_fwd_1;
   logic [16:0] w_fwd_2;

   assign w_fwd_1        = fwd_lookup(bus.fwd_addr_1);
   assign w_fwd_2        = fwd_lookup(bus.fwd_addr_2);
   assign bus.fwd_hit_1  = w_fwd_1[16];
   assign bus.fwd_data_1 = w_fwd_1[15:0];
   assign bus.fwd_hit_2  = w_fwd_2[16];
   assign bus.fwd_data_2 = w_fwd_2[15:0];
`else
   logic w_unused_fwd;

   assign w_unused_fwd   = ^{bus.fwd_addr_1, bus.fwd_addr_2};
   assign bus.fwd_hit_1  = 1'b0;
   assign bus.fwd_data_1 = 16'd0;
   assign bus.fwd_hit_2  = 1'b0;
   assign bus.fwd_data_2 = 16'd0;
`endif

endmodule
